// File: rtl/wdt_rstreq_if.sv
// Register bus and watchdog output bundle for wdt_rstreq.
// The master side drives the register bus; the slave side is the watchdog.
interface wdt_rstreq_if;
   logic [1:0]  reg_sel;
   logic        reg_wr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        wdt_irq;
   logic        wdt_rstreq;

   modport master (
      output reg_sel, reg_wr, reg_wdata,
      input  reg_rdata, wdt_irq, wdt_rstreq
   );

   modport slave (
      input  reg_sel, reg_wr, reg_wdata,
      output reg_rdata, wdt_irq, wdt_rstreq
   );
endinterface

// File: rtl/wdt_rstreq.sv
// Two-stage watchdog: first timeout raises wdt_irq, second timeout issues a RST_PULSE-cycle reset request.
// Optional macro WDT_PRESCALE_EN adds an 8-bit tick prescaler programmed through CTRL[15:8].
module wdt_rstreq #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned RST_PULSE = 4,
   parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
   input  logic        clk,
   input  logic        rst,
   wdt_rstreq_if.slave bus
);
   localparam logic [1:0]       SEL_LOAD   = 2'd0;
   localparam logic [1:0]       SEL_CTRL   = 2'd1;
   localparam logic [1:0]       SEL_KICK   = 2'd2;
   localparam logic [1:0]       SEL_STATUS = 2'd3;
   localparam int unsigned      PW         = $clog2(RST_PULSE + 1);
   localparam logic [PW-1:0]    PULSE_LEN  = PW'(RST_PULSE);
   localparam logic [PW-1:0]    PULSE_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0] load_r;
   logic [CNT_W-1:0] cnt_r;
   logic             en_r;
   logic             rst_en_r;
   logic             lock_r;
   logic             irq_r;
   logic             key_err_r;
   logic             rstreq_r;
   logic [PW-1:0]    pulse_cnt_r;

   logic             wr_load_s;
   logic             wr_ctrl_s;
   logic             wr_kick_s;
   logic             wr_status_s;
   logic             kick_ok_s;
   logic             en_rise_s;
   logic             tick_s;
   logic             cnt_zero_s;
   logic             fire_s;
   logic [7:0]       psc_rd_s;
   logic [31:0]      cnt_ext_s;
   logic             unused_s;

   // Write decode; LOAD and CTRL are write-protected once lock is set
   always_comb begin
      wr_load_s   = bus.reg_wr && (bus.reg_sel == SEL_LOAD) && !lock_r;
      wr_ctrl_s   = bus.reg_wr && (bus.reg_sel == SEL_CTRL) && !lock_r;
      wr_kick_s   = bus.reg_wr && (bus.reg_sel == SEL_KICK);
      wr_status_s = bus.reg_wr && (bus.reg_sel == SEL_STATUS);
      kick_ok_s   = wr_kick_s && (bus.reg_wdata == KICK_KEY);
      en_rise_s   = wr_ctrl_s && bus.reg_wdata[0] && !en_r;
      cnt_zero_s  = (cnt_r == '0);
      // A valid kick on the second-timeout tick suppresses the reset request
      fire_s      = tick_s && cnt_zero_s && irq_r && rst_en_r && !kick_ok_s;
   end

`ifdef WDT_PRESCALE_EN
   logic [7:0] psc_r;
   logic [7:0] pre_r;

   // Prescaler counts 0..psc and ticks on the wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_r <= 8'h00;
         pre_r <= 8'h00;
      end else begin
         if (wr_ctrl_s) begin
            psc_r <= bus.reg_wdata[15:8];
         end
         if (en_rise_s || kick_ok_s) begin
            pre_r <= 8'h00;
         end else if (en_r) begin
            pre_r <= (pre_r == psc_r) ? 8'h00 : pre_r + 8'h01;
         end
      end
   end

   assign tick_s   = en_r && (pre_r == psc_r);
   assign psc_rd_s = psc_r;
   assign unused_s = ^{bus.reg_wdata[31:16], bus.reg_wdata[7:3]};
`else
   assign tick_s   = en_r;
   assign psc_rd_s = 8'h00;
   assign unused_s = ^{bus.reg_wdata[31:8], bus.reg_wdata[7:3]};
`endif

   // Configuration registers, counter, interrupt and key-error state
   always_ff @(posedge clk) begin
      if (rst) begin
         load_r    <= '1;
         cnt_r     <= '1;
         en_r      <= 1'b0;
         rst_en_r  <= 1'b0;
         lock_r    <= 1'b0;
         irq_r     <= 1'b0;
         key_err_r <= 1'b0;
      end else begin
         if (wr_load_s) begin
            load_r <= bus.reg_wdata[CNT_W-1:0];
         end
         if (wr_ctrl_s) begin
            en_r     <= bus.reg_wdata[0];
            rst_en_r <= bus.reg_wdata[1];
            lock_r   <= lock_r | bus.reg_wdata[2];
         end

         if (wr_kick_s && !kick_ok_s) begin
            key_err_r <= 1'b1;
         end else if (wr_status_s && bus.reg_wdata[1]) begin
            key_err_r <= 1'b0;
         end

         if (kick_ok_s || en_rise_s) begin
            cnt_r <= load_r;
         end else if (tick_s) begin
            cnt_r <= cnt_zero_s ? load_r : cnt_r - CNT_ONE;
         end

         // Zero on a tick toggles irq: set on first timeout, cleared on the second
         if (kick_ok_s) begin
            irq_r <= 1'b0;
         end else if (tick_s && cnt_zero_s) begin
            irq_r <= ~irq_r;
         end else if (wr_status_s && bus.reg_wdata[0]) begin
            irq_r <= 1'b0;
         end
      end
   end

   // Reset-request pulse; a timeout while a pulse is running is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_cnt_r <= '0;
         rstreq_r    <= 1'b0;
      end else if (fire_s && (pulse_cnt_r == '0)) begin
         pulse_cnt_r <= PULSE_LEN;
         rstreq_r    <= 1'b1;
      end else if (pulse_cnt_r != '0) begin
         pulse_cnt_r <= pulse_cnt_r - PULSE_ONE;
         rstreq_r    <= (pulse_cnt_r > PULSE_ONE);
      end else begin
         rstreq_r    <= 1'b0;
      end
   end

   // Register read mux
   always_comb begin
      cnt_ext_s = 32'(cnt_r);
      case (bus.reg_sel)
         SEL_LOAD:   bus.reg_rdata = 32'(load_r);
         SEL_CTRL:   bus.reg_rdata = {16'h0000, psc_rd_s, 5'b00000, lock_r, rst_en_r, en_r};
         SEL_KICK:   bus.reg_rdata = 32'h0000_0000;
         SEL_STATUS: bus.reg_rdata = {cnt_ext_s[31:2], key_err_r, irq_r};
         default:    bus.reg_rdata = 32'h0000_0000;
      endcase
   end

   assign bus.wdt_irq    = irq_r;
   assign bus.wdt_rstreq = rstreq_r;
endmodule

// File: tb/tb_wdt_rstreq.sv
// Directed bench for wdt_rstreq: a vector table for the basic two-stage timeout,
// then hand-written sequences for kicks, key errors, lock, pulse overlap, reset and tick rate.
module tb_wdt_rstreq;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   wdt_rstreq_if bus ();

   wdt_rstreq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        irq;
      logic        rq;
      string       nm;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock with the given bus values; leaves reg_sel in place for readback
   task automatic cyc(input logic [1:0] sel, input logic wr, input logic [31:0] wd);
      bus.reg_sel   = sel;
      bus.reg_wr    = wr;
      bus.reg_wdata = wd;
      @(posedge clk);
      #1;
      bus.reg_wr    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] sel, output logic [31:0] v);
      bus.reg_sel = sel;
      #1;
      v = bus.reg_rdata;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2'd0, 1'b0, 32'h0);
      rst = 1'b0;
   endtask

   logic [31:0] v;
   logic [7:0]  exp_rq_seq;
   logic [7:0]  exp_irq_seq;
   int          n_ticks;
   logic [31:0] ctrl_val;

   initial begin
      rst           = 1'b1;
      bus.reg_sel   = 2'd0;
      bus.reg_wr    = 1'b0;
      bus.reg_wdata = 32'h0;
      cyc(2'd0, 1'b0, 32'h0);
      cyc(2'd0, 1'b0, 32'h0);
      rst = 1'b0;

      // sel wr wdata | expected rdata irq rq
      vecs[0]  = '{2'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, "rst_load"};
      vecs[1]  = '{2'd1, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "rst_ctrl"};
      vecs[2]  = '{2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "rst_kick"};
      vecs[3]  = '{2'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, "rst_status"};
      vecs[4]  = '{2'd0, 1'b1, 32'h3, 32'h0000_0003, 1'b0, 1'b0, "wr_load3"};
      vecs[5]  = '{2'd1, 1'b1, 32'h3, 32'h0000_0003, 1'b0, 1'b0, "wr_ctrl3"};
      vecs[6]  = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "cnt2"};
      vecs[7]  = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "cnt1"};
      vecs[8]  = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "cnt0"};
      vecs[9]  = '{2'd3, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, "irq_set"};
      vecs[10] = '{2'd3, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, "irq_hold2"};
      vecs[11] = '{2'd3, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, "irq_hold1"};
      vecs[12] = '{2'd3, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, "irq_hold0"};
      vecs[13] = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, "pulse1"};
      vecs[14] = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, "pulse2"};
      vecs[15] = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, "pulse3"};
      vecs[16] = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, "pulse4"};
      vecs[17] = '{2'd3, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, "pulse_end_irq"};
      vecs[18] = '{2'd3, 1'b1, 32'h1, 32'h0000_0000, 1'b0, 1'b0, "status_clr_irq"};
      vecs[19] = '{2'd3, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, "after_clr"};

      for (int i = 0; i < 20; i++) begin
         cyc(vecs[i].sel, vecs[i].wr, vecs[i].wdata);
         chk({vecs[i].nm, "_rdata"}, bus.reg_rdata, vecs[i].rdata);
         chk({vecs[i].nm, "_irq"}, 32'(bus.wdt_irq), 32'(vecs[i].irq));
         chk({vecs[i].nm, "_rq"}, 32'(bus.wdt_rstreq), 32'(vecs[i].rq));
      end

      // Regular valid kicks keep both outputs low
      do_reset();
      cyc(2'd0, 1'b1, 32'd10);
      cyc(2'd1, 1'b1, 32'h3);
      for (int i = 0; i < 100; i++) begin
         if ((i % 8) == 7) cyc(2'd2, 1'b1, 32'h5A5A_A5A5);
         else              cyc(2'd3, 1'b0, 32'h0);
         chk("kick_irq", 32'(bus.wdt_irq), 32'h0);
         chk("kick_rq", 32'(bus.wdt_rstreq), 32'h0);
      end
      rd(2'd3, v);
      chk("kick_keyerr", {31'h0, v[1]}, 32'h0);

      // Bad key flags key_err without reloading; STATUS write 2 clears it
      do_reset();
      cyc(2'd0, 1'b1, 32'h100);
      cyc(2'd1, 1'b1, 32'h1);
      cyc(2'd2, 1'b1, 32'h1234_5678);
      rd(2'd3, v);
      chk("badkey_status", v, 32'h0000_00FE);
      repeat (4) cyc(2'd3, 1'b0, 32'h0);
      chk("badkey_dec", bus.reg_rdata, 32'h0000_00FA);
      cyc(2'd3, 1'b1, 32'h2);
      chk("keyerr_clr", bus.reg_rdata, 32'h0000_00F8);
      cyc(2'd2, 1'b1, 32'h5A5A_A5A5);
      rd(2'd3, v);
      chk("goodkey_reload", v, 32'h0000_0100);

      // Valid kick on the second-timeout tick: no pulse, cnt reloaded, irq cleared
      do_reset();
      cyc(2'd0, 1'b1, 32'h4);
      cyc(2'd1, 1'b1, 32'h3);
      repeat (9) cyc(2'd3, 1'b0, 32'h0);
      chk("race_pre_status", bus.reg_rdata, 32'h0000_0001);
      cyc(2'd2, 1'b1, 32'h5A5A_A5A5);
      rd(2'd3, v);
      chk("race_status", v, 32'h0000_0004);
      chk("race_irq", 32'(bus.wdt_irq), 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("race_rq", 32'(bus.wdt_rstreq), 32'h0);
         cyc(2'd3, 1'b0, 32'h0);
      end

      // Lock freezes LOAD and CTRL but the watchdog keeps running
      do_reset();
      cyc(2'd0, 1'b1, 32'h2);
      cyc(2'd1, 1'b1, 32'h7);
      cyc(2'd0, 1'b1, 32'h5);
      cyc(2'd1, 1'b1, 32'h0);
      rd(2'd0, v);
      chk("lock_load", v, 32'h0000_0002);
      rd(2'd1, v);
      chk("lock_ctrl", v, 32'h0000_0007);
      cyc(2'd3, 1'b0, 32'h0);
      chk("lock_irq", 32'(bus.wdt_irq), 32'h1);
      repeat (3) cyc(2'd3, 1'b0, 32'h0);
      chk("lock_pulse1", 32'(bus.wdt_rstreq), 32'h1);
      cyc(2'd3, 1'b0, 32'h0);
      chk("lock_pulse2", 32'(bus.wdt_rstreq), 32'h1);

      // Reset on pulse cycle 2 drops the request immediately
      rst = 1'b1;
      cyc(2'd3, 1'b0, 32'h0);
      rst = 1'b0;
      chk("rst_mid_rq", 32'(bus.wdt_rstreq), 32'h0);
      chk("rst_mid_status", bus.reg_rdata, 32'hFFFF_FFFC);
      rd(2'd1, v);
      chk("rst_mid_ctrl", v, 32'h0000_0000);

      // LOAD=0: timeout every tick; overlapping timeouts do not extend the pulse
      exp_irq_seq = 8'b0101_0101;
      exp_rq_seq  = 8'b1001_1110;
      cyc(2'd0, 1'b1, 32'h0);
      cyc(2'd1, 1'b1, 32'h3);
      for (int i = 0; i < 8; i++) begin
         cyc(2'd3, 1'b0, 32'h0);
         chk("ovl_irq", 32'(bus.wdt_irq), 32'(exp_irq_seq[i]));
         chk("ovl_rq", 32'(bus.wdt_rstreq), 32'(exp_rq_seq[i]));
      end

      // Tick rate: LOAD=1, irq after 2 ticks (psc=3 stretches each tick to 4 cycles)
      do_reset();
`ifdef WDT_PRESCALE_EN
      n_ticks  = 8;
      ctrl_val = 32'h0000_0301;
`else
      n_ticks  = 2;
      ctrl_val = 32'h0000_0001;
`endif
      cyc(2'd0, 1'b1, 32'h1);
      cyc(2'd1, 1'b1, ctrl_val);
      for (int k = 1; k <= n_ticks; k++) begin
         cyc(2'd3, 1'b0, 32'h0);
         chk("rate_irq", 32'(bus.wdt_irq), (k == n_ticks) ? 32'h1 : 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
